// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN layer blocks.
// Holds the default element/vector sizes and the serializer FSM state type.
package cnn_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_NUM_NODES  = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } ser_state_t;

endpackage

// File: rtl/relu_unit.sv
// Combinational ReLU for one signed fixed-point element.
// Negative inputs (MSB set) become zero; everything else passes through.
import cnn_pkg::*;

module relu_unit #(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    assign dout = din[DATA_WIDTH-1] ? '0 : din;

endmodule

// File: rtl/dense_output_serializer.sv
// Captures a parallel dense-layer result vector and streams it out one element
// per handshake, in ascending node order, with optional ReLU on each element.
import cnn_pkg::*;

module dense_output_serializer #(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int NUM_NODES  = DEFAULT_NUM_NODES,
    parameter  int RELU_EN    = 1,
    localparam int IDX_W      = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_NODES*DATA_WIDTH-1:0] in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [IDX_W-1:0]                out_index,
    output logic                            out_last,
    output logic                            layer_active
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

    ser_state_t                      state, next_state;
    logic [NUM_NODES*DATA_WIDTH-1:0] buffer;
    logic [IDX_W-1:0]                idx;
    logic [DATA_WIDTH-1:0]           elem, elem_relu;
    logic                            at_last, out_hs, capture;

    assign at_last = (idx == LAST_IDX);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
        next_state   = state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        layer_active = 1'b0;
        out_hs       = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture    = 1'b1;
                    next_state = STREAM;
                end
            end
            STREAM: begin
                out_valid    = 1'b1;
                layer_active = 1'b1;
                out_last     = at_last;
                out_hs       = out_ready;
                // Last beat frees the buffer this cycle, so a waiting vector loads with no bubble.
                if (out_ready && at_last) begin
                    in_ready = 1'b1;
                    if (in_valid) capture    = 1'b1;
                    else          next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state  <= IDLE;
            idx    <= '0;
            // NOTE: the buffer is cleared on reset so out_data reads 0 straight after reset.
            buffer <= '0;
        end else begin
            state <= next_state;
            if (capture) begin
                buffer <= in_data;
                idx    <= '0;
            end else if (out_hs) begin
                idx <= at_last ? '0 : idx + 1'b1;
            end
        end
    end

    assign elem = buffer[idx*DATA_WIDTH +: DATA_WIDTH];

    relu_unit #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_relu (
        .din (elem),
        .dout(elem_relu)
    );

    assign out_data  = (RELU_EN != 0) ? elem_relu : elem;
    assign out_index = idx;

endmodule

// File: tb/tb_dense_output_serializer.sv
// Self-checking bench: two 4-node serializers (ReLU on/off) against a transaction-level
// model, plus directed scenarios and a single-node instance.
module tb_dense_output_serializer;

    localparam int DW = 16;
    localparam int NN = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic             in_valid, out_ready;
    logic [NN*DW-1:0] in_data;

    logic          a_in_ready, a_out_valid, a_out_last, a_layer_active;
    logic [DW-1:0] a_out_data;
    logic [IW-1:0] a_out_index;
    logic          b_in_ready, b_out_valid, b_out_last, b_layer_active;
    logic [DW-1:0] b_out_data;
    logic [IW-1:0] b_out_index;

    logic          c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last, c_layer_active;
    logic [DW-1:0] c_in_data, c_out_data;
    logic [0:0]    c_out_index;

    dense_output_serializer #(.DATA_WIDTH(DW), .NUM_NODES(NN), .RELU_EN(1)) u_dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_index(a_out_index), .out_last(a_out_last), .layer_active(a_layer_active));

    dense_output_serializer #(.DATA_WIDTH(DW), .NUM_NODES(NN), .RELU_EN(0)) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_index(b_out_index), .out_last(b_out_last), .layer_active(b_layer_active));

    dense_output_serializer #(.DATA_WIDTH(DW), .NUM_NODES(1), .RELU_EN(1)) u_dut_c (
        .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_index(c_out_index), .out_last(c_out_last), .layer_active(c_layer_active));

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: the vector being streamed and the position within it.
    logic [DW-1:0] m_vec [NN];
    int            m_pos  = 0;
    bit            m_busy = 1'b0;

    function automatic logic [DW-1:0] relu_ref(input logic [DW-1:0] x);
        return ($signed(x) < 0) ? '0 : x;
    endfunction

    function automatic bit m_in_ready();
        return !m_busy || (out_ready && m_pos == NN - 1);
    endfunction

    always @(posedge clk) begin
        bit hs, acc;
        if (reset) begin
            m_busy = 1'b0;
            m_pos  = 0;
        end else begin
            hs  = m_busy && out_ready;
            acc = in_valid && (!m_busy || (hs && m_pos == NN - 1));
            if (acc) begin
                for (int i = 0; i < NN; i++) m_vec[i] = in_data[i*DW +: DW];
                m_pos  = 0;
                m_busy = 1'b1;
            end else if (hs) begin
                if (m_pos == NN - 1) begin
                    m_busy = 1'b0;
                    m_pos  = 0;
                end else begin
                    m_pos++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("a_out_valid", a_out_valid, m_busy);
            check("a_layer_active", a_layer_active, m_busy);
            check("a_in_ready", a_in_ready, m_in_ready());
            check("b_out_valid", b_out_valid, m_busy);
            check("b_in_ready", b_in_ready, m_in_ready());
            if (m_busy) begin
                check("a_out_data", a_out_data, relu_ref(m_vec[m_pos]));
                check("a_out_index", a_out_index, m_pos);
                check("a_out_last", a_out_last, m_pos == NN - 1);
                check("b_out_data", b_out_data, m_vec[m_pos]);
                check("b_out_index", b_out_index, m_pos);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int            pat [4];
        logic [IW-1:0] got_idx [$];
        logic [DW-1:0] got_dat [$];
        logic [DW-1:0] ea [4];
        logic [DW-1:0] eb [4];
        bit            hold;

        pat = '{1, 0, 0, 1};
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", a_in_ready, 1);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_layer_active", a_layer_active, 0);
        check("rst_out_data", a_out_data, 0);
        check("rst_out_last", a_out_last, 0);
        check("rst_c_in_ready", c_in_ready, 1);
        check("rst_c_out_valid", c_out_valid, 0);

        // Basic stream of 1,2,3,4
        tick(); in_valid = 1'b1; in_data = {16'h0004, 16'h0003, 16'h0002, 16'h0001}; out_ready = 1'b1;
        tick(); in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("basic_data", a_out_data, k + 1);
            check("basic_index", a_out_index, k);
            check("basic_last", a_out_last, k == 3);
            if (k < 3) tick();
        end
        tick();
        @(negedge clk);
        check("basic_idle_valid", a_out_valid, 0);
        check("basic_idle_active", a_layer_active, 0);

        // ReLU on/off with boundary values
        tick(); in_valid = 1'b1; in_data = {16'h0000, 16'h7FFF, 16'hFFFF, 16'h8000};
        tick(); in_valid = 1'b0;
        ea = '{16'h0000, 16'h0000, 16'h7FFF, 16'h0000};
        eb = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("relu_on_data", a_out_data, ea[k]);
            check("relu_off_data", b_out_data, eb[k]);
            if (k < 3) tick();
        end
        tick();

        // Stalls: out_ready pattern 1,0,0,1
        in_valid = 1'b1; in_data = {16'h00D3, 16'h00C2, 16'h00B1, 16'h00A0};
        tick(); in_valid = 1'b0; out_ready = pat[0][0];
        for (int cyc = 0; cyc < 40 && got_idx.size() < 4; cyc++) begin
            @(negedge clk);
            if (a_out_valid && out_ready) begin
                got_idx.push_back(a_out_index);
                got_dat.push_back(a_out_data);
            end
            tick();
            out_ready = pat[(cyc + 1) % 4][0];
        end
        check("stall_beats", got_idx.size(), 4);
        for (int k = 0; k < got_idx.size(); k++) begin
            check("stall_index", got_idx[k], k);
            check("stall_data", got_dat[k], 16'h00A0 + 16'(k * 17));
        end
        out_ready = 1'b1;
        repeat (4) tick();

        // Back-to-back vectors with in_valid held through the stream
        in_valid = 1'b1; in_data = {16'h0014, 16'h0013, 16'h0012, 16'h0011};
        tick();
        in_data = {16'h0024, 16'h0023, 16'h0022, 16'h0021};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("b2b_active", a_layer_active, 1);
            check("b2b_v1_data", a_out_data, 16'h0011 + 16'(k));
            if (k == 3) check("b2b_in_ready_last", a_in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_v2_first", a_out_data, 16'h0021);
        check("b2b_v2_index", a_out_index, 0);
        check("b2b_v2_active", a_layer_active, 1);
        repeat (4) tick();

        // Reset mid-stream after two elements; reset must also beat a simultaneous capture
        in_valid = 1'b1; in_data = {16'h0034, 16'h0033, 16'h0032, 16'h0031};
        tick(); in_valid = 1'b0;
        @(negedge clk); check("mid_e0", a_out_data, 16'h0031);
        tick();
        @(negedge clk); check("mid_e1", a_out_data, 16'h0032);
        tick();
        reset = 1'b1; in_valid = 1'b1;
        tick();
        tick();
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", a_out_valid, 0);
        check("mid_rst_in_ready", a_in_ready, 1);
        check("mid_rst_active", a_layer_active, 0);
        check("mid_rst_data", a_out_data, 0);
        tick(); in_valid = 1'b1; in_data = {16'h0044, 16'h0043, 16'h0042, 16'h0041};
        tick(); in_valid = 1'b0;
        @(negedge clk);
        check("restart_index", a_out_index, 0);
        check("restart_data", a_out_data, 16'h0041);
        repeat (4) tick();

        // Randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            hold = in_valid && !m_in_ready() && !reset;
            tick();
            reset = ($urandom_range(0, 99) == 0);
            if (!hold) begin
                in_valid = ($urandom_range(0, 2) != 0);
                in_data  = {$urandom, $urandom};
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0; reset = 1'b0; out_ready = 1'b1;
        repeat (8) tick();

        // Single-node instance: every beat is both first and last
        c_in_valid = 1'b1; c_in_data = 16'h0005; c_out_ready = 1'b1;
        tick();
        c_in_data = 16'h8003;
        @(negedge clk);
        check("n1_valid", c_out_valid, 1);
        check("n1_data", c_out_data, 16'h0005);
        check("n1_index", c_out_index, 0);
        check("n1_last", c_out_last, 1);
        check("n1_in_ready", c_in_ready, 1);
        tick();
        c_in_valid = 1'b0; c_out_ready = 1'b0;
        @(negedge clk);
        check("n1_b2b_valid", c_out_valid, 1);
        check("n1_b2b_relu", c_out_data, 16'h0000);
        check("n1_stall_in_ready", c_in_ready, 0);
        tick();
        @(negedge clk);
        check("n1_stall_hold", c_out_valid, 1);
        check("n1_stall_last", c_out_last, 1);
        c_out_ready = 1'b1;
        tick();
        @(negedge clk);
        check("n1_idle_valid", c_out_valid, 0);
        check("n1_idle_active", c_layer_active, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dense_output_serializer.md
DENSE_OUTPUT_SERIALIZER -- requirements
Module: dense_output_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, bit width of one signed fixed-point element.
REQ-002 SHALL have parameter NUM_NODES, default 16, elements per captured vector (legal range >= 1).
REQ-003 SHALL have parameter RELU_EN, default 1, which enables ReLU on emitted elements.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  upstream vector valid.
REQ-007 SHALL have port in_ready  output  1  serializer can accept a vector.
REQ-008 SHALL have port in_data  input  NUM_NODES*DATA_WIDTH  parallel dense-layer result, node i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port out_valid  output  1  out_data valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts element.
REQ-011 SHALL have port out_data  output  DATA_WIDTH  current element.
REQ-012 SHALL have port out_index  output  max(1,$clog2(NUM_NODES))  node index of out_data.
REQ-013 SHALL have port out_last  output  1  high on the element with index NUM_NODES-1.
REQ-014 SHALL have port layer_active  output  1  high while a vector is being streamed; drives the next layer's layer_active.

Function
REQ-015 SHALL implement a two-state FSM with states IDLE and STREAM.
REQ-016 In IDLE, in_ready SHALL be 1, out_valid SHALL be 0, and layer_active SHALL be 0.
REQ-017 A transfer SHALL occur when in_valid && in_ready at a rising edge; in_data is registered into an internal buffer, the index is cleared to 0, and the FSM enters STREAM.
REQ-018 out_valid SHALL assert in the cycle after the accepting edge, giving a latency of 1 from capture to first element.
REQ-019 Elements SHALL be emitted in ascending node order 0..NUM_NODES-1, one per out_valid && out_ready handshake.
REQ-020 While out_valid && !out_ready, out_data, out_index and out_last SHALL hold stable.
REQ-021 When RELU_EN=1, an element whose MSB is 1 (negative) SHALL be emitted as 0; otherwise the element SHALL pass through unchanged.
REQ-022 No width growth or saturation SHALL occur: out_data is exactly DATA_WIDTH bits.
REQ-023 When the handshake occurs on out_last, the index SHALL wrap to 0.
REQ-024 When that handshake coincides with in_valid, the new vector SHALL be captured in the same cycle and the FSM SHALL stay in STREAM (back-to-back, no bubble).
REQ-025 When that handshake occurs without in_valid, the FSM SHALL return to IDLE.
REQ-026 in_ready SHALL be (state==IDLE) || (out_valid && out_ready && out_last); this combinational path from out_ready is intentional.
REQ-027 In STREAM, in_valid without the last-beat handshake SHALL be ignored, and upstream SHALL hold in_data.
REQ-028 When NUM_NODES=1, every element SHALL be both first and last (out_last=1 whenever out_valid).
REQ-029 layer_active SHALL equal (state==STREAM).

Reset
REQ-030 On reset, the FSM SHALL enter IDLE, the index SHALL clear to 0, and out_valid, out_last and layer_active SHALL be 0.
REQ-031 On reset, out_data SHALL be 0 and in_ready SHALL be 1 from the first cycle after reset deasserts.
REQ-032 A reset asserted mid-stream SHALL discard the buffered vector, and no further elements of that vector SHALL be emitted.
REQ-033 Reset SHALL take priority over any simultaneous handshake.

Structure
REQ-034 Shared package cnn_pkg SHALL hold the default DATA_WIDTH and NUM_NODES constants and a typedef for the FSM state enum.
REQ-035 ReLU SHALL be a small sub-module, relu_unit (parameter DATA_WIDTH, combinational), shared with the conv/dense node path.
REQ-036 The buffer SHALL be a single NUM_NODES*DATA_WIDTH register, with an indexed part-select mux feeding relu_unit.

Verification (NUM_NODES=4, DATA_WIDTH=16 unless stated)
REQ-037 Scenario: in_data={16'h0004,16'h0003,16'h0002,16'h0001}, out_ready=1 -> out_data 1,2,3,4 on 4 consecutive cycles starting 1 cycle after capture, out_last on 4, then IDLE.
REQ-038 Scenario: RELU_EN=1 with elements {16'h8000,16'hFFFF,16'h7FFF,16'h0000} -> outputs 0,0,7FFF,0; with RELU_EN=0 the outputs equal the inputs.
REQ-039 Scenario: out_ready toggled 1,0,0,1,... -> each element held stable during stalls, no element lost or duplicated, out_index sequence 0,1,2,3.
REQ-040 Scenario: second vector presented with in_valid held through the stream -> accepted on the out_last handshake, element 0 of the new vector in the next cycle with no gap, layer_active continuously 1.
REQ-041 Scenario: reset asserted after 2 elements emitted -> next cycle out_valid=0, in_ready=1, layer_active=0; a new vector restarts at index 0.
REQ-042 Scenario: NUM_NODES=1 with value 16'h0005 -> single beat with out_last=1 and out_index=0.
